// File: rtl/mcu_pkg.sv
// mcu_pkg: shared register-file defaults, zero-register index and index type
package mcu_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDRESS_WIDTH = 3;
  localparam int ZERO_REG = 0;
  typedef logic [ADDRESS_WIDTH-1:0] reg_idx_t;
endpackage

// File: rtl/write_enable_decoder.sv
// write_enable_decoder: one-hot write-enable decode with optional R0 protection
module write_enable_decoder
  import mcu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = mcu_pkg::ADDRESS_WIDTH,
  parameter bit ZERO_REG_PROTECT = 1'b1,
  localparam int NUM_REGS = 2 ** ADDRESS_WIDTH
) (
  input  logic                     enable,
  input  logic [ADDRESS_WIDTH-1:0] address,
  output logic [NUM_REGS-1:0]      onehot
);
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_IDX = ADDRESS_WIDTH'(ZERO_REG);
  logic w_blocked;
  always_comb begin
    w_blocked = ZERO_REG_PROTECT && address == ZERO_IDX;
    onehot = (enable && !w_blocked) ? NUM_REGS'(1) << address : '0;
  end
endmodule

// File: rtl/reg_file.sv
// reg_file: 1W/2R register file with optional R0 protection and write-to-read bypass
module reg_file
  import mcu_pkg::*;
#(
  parameter int DATA_WIDTH = mcu_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = mcu_pkg::ADDRESS_WIDTH,
  parameter bit ZERO_REG_PROTECT = 1'b1,
  parameter bit BYPASS = 1'b1,
  localparam int NUM_REGS = 2 ** ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     we,
  input  logic [ADDRESS_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [ADDRESS_WIDTH-1:0] raddr_a,
  input  logic [ADDRESS_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0]    rdata_a,
  output logic [DATA_WIDTH-1:0]    rdata_b,
  output logic [NUM_REGS-1:0]      wen_onehot
);
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_IDX = ADDRESS_WIDTH'(ZERO_REG);
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] w_wen;
  logic w_byp_a, w_byp_b;
  write_enable_decoder #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .ZERO_REG_PROTECT(ZERO_REG_PROTECT)
  ) u_dec (
    .enable(we),
    .address(waddr),
    .onehot(w_wen)
  );
  assign wen_onehot = w_wen;
  // clr wins over a same-edge write; the decoded enable stays visible regardless
  always_ff @(posedge clk or posedge rst)
    if (rst) r_regs <= '{default: '0};
    else if (clr) r_regs <= '{default: '0};
    else for (int i = 0; i < NUM_REGS; i++) if (w_wen[i]) r_regs[i] <= wdata;
  always_comb begin
    w_byp_a = BYPASS && we && !clr && raddr_a == waddr;
    w_byp_b = BYPASS && we && !clr && raddr_b == waddr;
    rdata_a = (ZERO_REG_PROTECT && raddr_a == ZERO_IDX) ? '0 : w_byp_a ? wdata : r_regs[raddr_a];
    rdata_b = (ZERO_REG_PROTECT && raddr_b == ZERO_IDX) ? '0 : w_byp_b ? wdata : r_regs[raddr_b];
  end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: four reg_file configurations driven in lockstep, checked by a scoreboard
module tb_reg_file;
  typedef struct {
    logic [3:0][31:0] a;
    logic [3:0][31:0] b;
    logic [3:0][31:0] w;
    string nm;
  } exp_t;
  logic clk = 0, rst = 1, clr = 0, we = 0;
  logic [4:0] waddr = 0, raddr_a = 0, raddr_b = 0;
  logic [31:0] wdata = 0;
  logic [7:0] a0, a1, a2, b0, b1, b2, w0, w1, w2;
  logic [31:0] a3, b3, w3;
  logic [3:0][31:0] act_a, act_b, act_w;
  int dw [4] = '{8, 8, 8, 32};
  int aw [4] = '{3, 3, 3, 5};
  int zrp [4] = '{1, 0, 1, 1};
  int byp [4] = '{1, 1, 0, 1};
  logic [31:0] m [4][32];
  exp_t q [$];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  reg_file #(.DATA_WIDTH(8), .ADDRESS_WIDTH(3), .ZERO_REG_PROTECT(1), .BYPASS(1)) u0 (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr[2:0]), .wdata(wdata[7:0]),
    .raddr_a(raddr_a[2:0]), .raddr_b(raddr_b[2:0]), .rdata_a(a0), .rdata_b(b0), .wen_onehot(w0));
  reg_file #(.DATA_WIDTH(8), .ADDRESS_WIDTH(3), .ZERO_REG_PROTECT(0), .BYPASS(1)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr[2:0]), .wdata(wdata[7:0]),
    .raddr_a(raddr_a[2:0]), .raddr_b(raddr_b[2:0]), .rdata_a(a1), .rdata_b(b1), .wen_onehot(w1));
  reg_file #(.DATA_WIDTH(8), .ADDRESS_WIDTH(3), .ZERO_REG_PROTECT(1), .BYPASS(0)) u2 (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr[2:0]), .wdata(wdata[7:0]),
    .raddr_a(raddr_a[2:0]), .raddr_b(raddr_b[2:0]), .rdata_a(a2), .rdata_b(b2), .wen_onehot(w2));
  reg_file #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5), .ZERO_REG_PROTECT(1), .BYPASS(1)) u3 (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(a3), .rdata_b(b3), .wen_onehot(w3));
  assign act_a = {a3, 24'd0, a2, 24'd0, a1, 24'd0, a0};
  assign act_b = {b3, 24'd0, b2, 24'd0, b1, 24'd0, b0};
  assign act_w = {w3, 24'd0, w2, 24'd0, w1, 24'd0, w0};

  function automatic logic [31:0] rd(int k, int ra, int wa, logic w, logic c, logic [31:0] d);
    if (zrp[k] != 0 && ra == 0) return 0;
    if (byp[k] != 0 && w && !c && ra == wa) return d;
    return m[k][ra];
  endfunction

  task automatic drive(input logic r, input logic c, input logic w, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb,
                       input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; clr = c; we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
    for (int k = 0; k < 4; k++) begin
      int amask, x, y, z;
      logic [31:0] d;
      logic en;
      amask = (1 << aw[k]) - 1;
      x = int'(ra) & amask;
      y = int'(rb) & amask;
      z = int'(wa) & amask;
      d = wd & (32'hFFFF_FFFF >> (32 - dw[k]));
      en = w && !(zrp[k] != 0 && z == 0);
      if (r) for (int j = 0; j < 32; j++) m[k][j] = 0;
      e.w[k] = en ? 32'd1 << z : 32'd0;
      e.a[k] = rd(k, x, z, w, c, d);
      e.b[k] = rd(k, y, z, w, c, d);
      if (r || c) for (int j = 0; j < 32; j++) m[k][j] = 0;
      else if (en) m[k][z] = d;
    end
    e.nm = nm;
    q.push_back(e);
  endtask

  function automatic void chk(string nm, string fld, int k, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s cfg%0d: got %h want %h @%0t", nm, fld, k, act, exp, $time);
    end
  endfunction

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int k = 0; k < 4; k++) begin
        chk(e.nm, "rdata_a", k, act_a[k], e.a[k]);
        chk(e.nm, "rdata_b", k, act_b[k], e.b[k]);
        chk(e.nm, "wen_onehot", k, act_w[k], e.w[k]);
      end
    end
  end

  initial begin
    drive(1, 0, 0, 0, 0, 1, 2, "rst_init");
    for (int i = 1; i < 8; i++) drive(0, 0, 1, 5'(i), 32'hAA, 5'(i), 0, "fill_aa");
    drive(1, 0, 0, 0, 0, 1, 7, "rst_async");
    drive(1, 0, 0, 0, 0, 3, 5, "rst_hold");
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 0, 5'(i), 5'(7 - i), "post_rst");
    for (int i = 1; i < 8; i++) drive(0, 0, 1, 5'(i), 32'h10 + i, 5'(i), 5'(i - 1), "sweep_wr");
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 0, 5'(i), 5'(7 - i), "sweep_rd");
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 0, 5'(7 - i), 5'(i), "sweep_rd2");
    drive(0, 0, 1, 0, 32'h5A, 0, 0, "zero_wr");
    drive(0, 0, 0, 0, 0, 0, 0, "zero_rd");
    drive(0, 0, 1, 3, 32'h11, 1, 2, "byp_pre");
    drive(0, 0, 1, 3, 32'h22, 3, 3, "byp_same");
    drive(0, 0, 0, 0, 0, 3, 3, "byp_after");
    drive(0, 0, 1, 2, 32'h33, 1, 1, "clr_pre");
    drive(0, 1, 1, 2, 32'h44, 2, 3, "clr_edge");
    drive(0, 0, 0, 0, 0, 2, 3, "clr_after");
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 0, 5'(i), 5'(i + 24), "clr_all");
    drive(0, 0, 1, 31, 32'hDEADBEEF, 31, 16, "wide31");
    drive(0, 0, 1, 16, 32'h12345678, 31, 16, "wide16");
    drive(0, 0, 0, 0, 0, 31, 16, "wide_rd");
    drive(1, 0, 1, 5, 32'h77, 5, 5, "rst_midwr");
    drive(0, 0, 0, 0, 0, 5, 16, "rst_midwr_rd");
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0, 1'($urandom), 5'($urandom),
            $urandom, 5'($urandom), 5'($urandom), "rand");
    drive(0, 0, 0, 0, 0, 0, 0, "idle");
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
